// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - LZW code/char geometry and decoder state encoding shared with the compressor
package lzw_pkg;
  localparam int CODE_W     = 12;
  localparam int CHAR_W     = 8;
  localparam int FIRST_FREE = 256;
  localparam int DICT_SIZE  = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    EMIT = 2'd2,
    ADD  = 2'd3
  } lzwState_t;
endpackage

// File: rtl/lzw_stack.sv
// rtl/lzw_stack.sv - character LIFO that reverses a dictionary chain into output order
module lzw_stack
  import lzw_pkg::*;
#(
  parameter int DEPTH = DICT_SIZE,
  parameter int WIDTH = CHAR_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] topIdx;

  assign topIdx = count[ADDR_W-1:0] - ADDR_W'(1);
  assign top    = mem[topIdx];
  assign empty  = (count == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (push) begin
      count <= count + (ADDR_W+1)'(1);
    end else if (pop && !empty) begin
      count <= count - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[count[ADDR_W-1:0]] <= pushData;
    end
  end
endmodule

// File: rtl/lzw_decoder.sv
// rtl/lzw_decoder.sv - LZW decoder: walks the prefix chain onto a stack, emits chars, then adds one entry
module lzw_decoder
  import lzw_pkg::*;
#(
  parameter int CODE_W     = lzw_pkg::CODE_W,
  parameter int CHAR_W     = lzw_pkg::CHAR_W,
  parameter int FIRST_FREE = lzw_pkg::FIRST_FREE,
  parameter int DICT_SIZE  = lzw_pkg::DICT_SIZE
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              iClear,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iCodeValid,
  output logic              oCodeReady,
  output logic [CHAR_W-1:0] oChar,
  output logic              oCharValid,
  input  logic              iCharReady,
  output logic              oDictFull,
  output logic              oError
);
  localparam logic [CODE_W:0] FreeCode = (CODE_W+1)'(FIRST_FREE);
  localparam logic [CODE_W:0] DictEnd  = (CODE_W+1)'(DICT_SIZE);

  lzwState_t         state, stateNext;
  logic [CODE_W:0]   nextCode, nextCodeNext;
  logic [CODE_W-1:0] prev, prevNext, cur, curNext, code, codeNext;
  logic              prevValid, prevValidNext, errorNext;
  logic [CHAR_W-1:0] firstChar, firstCharNext;
  logic [CODE_W-1:0] prefixTbl [DICT_SIZE];
  logic [CHAR_W-1:0] suffixTbl [DICT_SIZE];
  logic              push, pop, stackEmpty, tblWrite;
  logic [CHAR_W-1:0] pushData, stackTop;
  logic [CODE_W:0]   codeExt;
  logic              dictRoom;

  assign codeExt    = {1'b0, iCode};
  assign dictRoom   = (nextCode < DictEnd);
  assign oCodeReady = (state == IDLE) && !iClear;
  assign oCharValid = (state == EMIT) && !stackEmpty;
  assign oChar      = oCharValid ? stackTop : '0;
  assign oDictFull  = (nextCode == DictEnd);

  always_comb begin
    stateNext     = state;
    nextCodeNext  = nextCode;
    prevNext      = prev;
    prevValidNext = prevValid;
    firstCharNext = firstChar;
    curNext       = cur;
    codeNext      = code;
    errorNext     = oError;
    push          = 1'b0;
    pop           = 1'b0;
    pushData      = '0;
    tblWrite      = 1'b0;
    case (state)
      IDLE: begin
        if (iClear) begin
          nextCodeNext  = FreeCode;
          prevValidNext = 1'b0;
        end else if (iCodeValid) begin
          if (codeExt < nextCode && (prevValid || codeExt < FreeCode)) begin
            curNext   = iCode;
            codeNext  = iCode;
            stateNext = WALK;
          end else if (codeExt == nextCode && prevValid && dictRoom) begin
            // KwKwK: the code being defined is prev + first char of prev
            push      = 1'b1;
            pushData  = firstChar;
            curNext   = prev;
            codeNext  = iCode;
            stateNext = WALK;
          end else begin
            errorNext = 1'b1;
          end
        end
      end
      WALK: begin
        push = 1'b1;
        if ({1'b0, cur} >= FreeCode) begin
          pushData = suffixTbl[cur];
          curNext  = prefixTbl[cur];
        end else begin
          pushData      = cur[CHAR_W-1:0];
          firstCharNext = cur[CHAR_W-1:0];
          stateNext     = EMIT;
        end
      end
      EMIT: begin
        if (!stackEmpty) begin
          pop = iCharReady;
        end else if (prevValid && dictRoom) begin
          stateNext = ADD;
        end else begin
          prevNext      = code;
          prevValidNext = 1'b1;
          stateNext     = IDLE;
        end
      end
      ADD: begin
        tblWrite     = 1'b1;
        nextCodeNext = nextCode + (CODE_W+1)'(1);
        prevNext     = code;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      nextCode  <= FreeCode;
      prev      <= '0;
      prevValid <= 1'b0;
      firstChar <= '0;
      cur       <= '0;
      code      <= '0;
      oError    <= 1'b0;
    end else begin
      state     <= stateNext;
      nextCode  <= nextCodeNext;
      prev      <= prevNext;
      prevValid <= prevValidNext;
      firstChar <= firstCharNext;
      cur       <= curNext;
      code      <= codeNext;
      oError    <= errorNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (tblWrite && !Reset) begin
      prefixTbl[nextCode[CODE_W-1:0]] <= prev;
      suffixTbl[nextCode[CODE_W-1:0]] <= firstChar;
    end
  end

  lzw_stack #(
    .DEPTH(DICT_SIZE),
    .WIDTH(CHAR_W)
  ) uStack (
    .Clk     (Clk),
    .Reset   (Reset),
    .push    (push),
    .pop     (pop),
    .pushData(pushData),
    .top     (stackTop),
    .empty   (stackEmpty)
  );
endmodule

// File: tb/tb_lzw_decoder.sv
// tb/tb_lzw_decoder.sv - directed LZW decode sequences checked against an expected-char scoreboard
module tb_lzw_decoder;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        iClear = 1'b0;
  logic [11:0] iCode = '0;
  logic        iCodeValid = 1'b0;
  logic        oCodeReady;
  logic [7:0]  oChar;
  logic        oCharValid;
  logic        iCharReady = 1'b1;
  logic        oDictFull;
  logic        oError;

  int          passCnt = 0;
  int          checkCnt = 0;
  logic [7:0]  expQ [$];
  logic [7:0]  lits [3841];

  always #5 Clk = ~Clk;

  lzw_decoder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .iClear    (iClear),
    .iCode     (iCode),
    .iCodeValid(iCodeValid),
    .oCodeReady(oCodeReady),
    .oChar     (oChar),
    .oCharValid(oCharValid),
    .iCharReady(iCharReady),
    .oDictFull (oDictFull),
    .oError    (oError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Every accepted char must match the oldest queued expectation; 256 flags "nothing expected".
  always @(negedge Clk) begin
    if (!Reset && oCharValid && iCharReady) begin
      logic [31:0] e;
      if (expQ.size() > 0) e = 32'(expQ.pop_front());
      else e = 32'h100;
      check("char", 32'(oChar), e);
    end
  end

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1; iCodeValid = 1'b0; iClear = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    expQ.delete();
  endtask

  task automatic sendCode(input logic [11:0] c);
    int n = 0;
    @(negedge Clk);
    iCode = c; iCodeValid = 1'b1;
    while (!oCodeReady && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check("accept_ready", 32'(oCodeReady), 1);
    @(posedge Clk);
    #1 iCodeValid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge Clk);
    while ((expQ.size() != 0 || !oCodeReady) && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    check("drain_queue", 32'(expQ.size()), 0);
  endtask

  task automatic waitCharValid();
    int n = 0;
    @(negedge Clk);
    while (!oCharValid && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("char_valid_wait", 32'(oCharValid), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge Clk);
    @(negedge Clk);
    check("rst_ready", 32'(oCodeReady), 1);
    check("rst_charvalid", 32'(oCharValid), 0);
    check("rst_char", 32'(oChar), 0);
    check("rst_error", 32'(oError), 0);
    check("rst_full", 32'(oDictFull), 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_release_ready", 32'(oCodeReady), 1);

    // 65,66,256,258 -> A B AB ABA, then re-read 257 and 258
    expQ.push_back(8'd65);
    sendCode(12'd65);
    @(negedge Clk); check("lat_lit_walk", 32'(oCharValid), 0);
    @(negedge Clk); check("lat_lit_emit", 32'(oCharValid), 1);
    waitDrain();
    expQ.push_back(8'd66);
    sendCode(12'd66);
    waitDrain();
    expQ.push_back(8'd65); expQ.push_back(8'd66);
    sendCode(12'd256);
    @(negedge Clk); check("lat_chain_walk1", 32'(oCharValid), 0);
    @(negedge Clk); check("lat_chain_walk2", 32'(oCharValid), 0);
    @(negedge Clk); check("lat_chain_emit", 32'(oCharValid), 1);
    waitDrain();
    expQ.push_back(8'd65); expQ.push_back(8'd66); expQ.push_back(8'd65);
    sendCode(12'd258);
    waitDrain();
    expQ.push_back(8'd66); expQ.push_back(8'd65);
    sendCode(12'd257);
    waitDrain();
    expQ.push_back(8'd65); expQ.push_back(8'd66); expQ.push_back(8'd65);
    sendCode(12'd258);
    waitDrain();
    check("seq_error", 32'(oError), 0);

    // illegal first code, then a literal still decodes
    doReset();
    sendCode(12'd300);
    @(negedge Clk);
    check("illegal_error", 32'(oError), 1);
    check("illegal_ready", 32'(oCodeReady), 1);
    check("illegal_nochar", 32'(oCharValid), 0);
    expQ.push_back(8'd67);
    sendCode(12'd67);
    waitDrain();
    check("illegal_sticky", 32'(oError), 1);

    // backpressure holds the char
    doReset();
    iCharReady = 1'b0;
    expQ.push_back(8'd72);
    sendCode(12'd72);
    waitCharValid();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("hold_char", 32'(oChar), 72);
      check("hold_valid", 32'(oCharValid), 1);
      check("hold_ready", 32'(oCodeReady), 0);
    end
    @(posedge Clk);
    #1 iCharReady = 1'b1;
    waitDrain();

    // iClear blocks acceptance and flushes the dictionary
    doReset();
    expQ.push_back(8'd65);
    sendCode(12'd65);
    waitDrain();
    expQ.push_back(8'd66);
    sendCode(12'd66);
    waitDrain();
    @(negedge Clk);
    iClear = 1'b1; iCode = 12'd65; iCodeValid = 1'b1;
    #1 check("clear_ready", 32'(oCodeReady), 0);
    @(posedge Clk);
    #1 iClear = 1'b0; iCodeValid = 1'b0;
    @(negedge Clk);
    check("clear_idle", 32'(oCodeReady), 1);
    check("clear_nochar", 32'(oCharValid), 0);
    sendCode(12'd256);
    @(negedge Clk);
    check("clear_256_error", 32'(oError), 1);

    // reset during EMIT of ABA
    doReset();
    expQ.push_back(8'd65);
    sendCode(12'd65);
    waitDrain();
    expQ.push_back(8'd66);
    sendCode(12'd66);
    waitDrain();
    expQ.push_back(8'd65); expQ.push_back(8'd66);
    sendCode(12'd256);
    waitDrain();
    iCharReady = 1'b0;
    sendCode(12'd258);
    waitCharValid();
    check("emit_first", 32'(oChar), 65);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_emit_valid", 32'(oCharValid), 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_emit_ready", 32'(oCodeReady), 1);
    check("rst_emit_error", 32'(oError), 0);
    check("rst_emit_full", 32'(oDictFull), 0);
    @(posedge Clk);
    #1 iCharReady = 1'b1;
    sendCode(12'd256);
    @(negedge Clk);
    check("rst_emit_256_error", 32'(oError), 1);
    expQ.push_back(8'd65);
    sendCode(12'd65);
    waitDrain();

    // fill all 3840 free entries with literal pairs
    doReset();
    for (int i = 0; i < 3841; i++) lits[i] = 8'((i * 37 + 11) % 256);
    for (int i = 0; i < 3841; i++) begin
      if (i == 3840) check("full_before", 32'(oDictFull), 0);
      expQ.push_back(lits[i]);
      sendCode({4'd0, lits[i]});
    end
    waitDrain();
    check("full_flag", 32'(oDictFull), 1);
    expQ.push_back(lits[3839]); expQ.push_back(lits[3840]);
    sendCode(12'd4095);
    waitDrain();
    check("full_still", 32'(oDictFull), 1);
    check("full_error", 32'(oError), 0);
    expQ.push_back(lits[3838]); expQ.push_back(lits[3839]);
    sendCode(12'd4094);
    waitDrain();
    check("full_after", 32'(oDictFull), 1);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
